// File: rtl/dma_bram_responder.sv
// dma_bram_responder: memory-side DMA responder backed by an on-chip block RAM.
// Independent read and write engines, each with its own FIFO and completion
// tracking, so AFU logic can be exercised without a host.
// Optional feature: define DMA_RESP_BACKPRESSURE_EN to insert LFSR-driven stalls
// on RAM read issue and RAM write commit.
module dma_bram_responder #(
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 10,
    parameter int SIZE_WIDTH    = 16,
    parameter int RD_FIFO_DEPTH = 4,
    parameter int WR_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_go,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [SIZE_WIDTH-1:0] rd_size,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  rd_done,
    input  logic                  wr_go,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [SIZE_WIDTH-1:0] wr_size,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  wr_done,
    output logic                  host_wr_completed
);

    localparam int RD_PW = $clog2(RD_FIFO_DEPTH);
    localparam int RD_CW = RD_PW + 1;
    localparam int WR_PW = $clog2(WR_FIFO_DEPTH);
    localparam int WR_CW = WR_PW + 1;

    typedef enum logic [1:0] {RD_IDLE, RD_ACTIVE, RD_DONE} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_ACTIVE, WR_DONE} wr_state_t;

    // ------------------------------------------------------------------
    // Stall generation
    // ------------------------------------------------------------------
    logic rd_stall;
    logic wr_stall;

`ifdef DMA_RESP_BACKPRESSURE_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) used as a stall pattern.
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign rd_stall = lfsr[0];
    assign wr_stall = lfsr[1];
`else
    assign rd_stall = 1'b0;
    assign wr_stall = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Shared dual-port RAM
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_ram_q;

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    rd_state_t             rd_state, rd_state_next;
    logic [ADDR_WIDTH-1:0] rd_cur_addr;
    logic [SIZE_WIDTH-1:0] rd_size_q;
    logic [SIZE_WIDTH-1:0] rd_issued;
    logic [SIZE_WIDTH-1:0] rd_popped;
    logic                  rd_pend;      // RAM output register holds a line bound for the FIFO
    logic [DATA_WIDTH-1:0] rd_fifo [RD_FIFO_DEPTH];
    logic [RD_PW-1:0]      rd_wp, rd_rp;
    logic [RD_CW-1:0]      rd_count;
    logic                  rd_issue;
    logic                  rd_pop;

    // Read FSM next state, issue/pop strobes and status outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        rd_state_next = rd_state;
        rd_pop        = rd_en && (rd_count != '0) && !rd_go;
        rd_issue      = (rd_state == RD_ACTIVE) && !rd_go && !rd_stall &&
                        (rd_issued != rd_size_q) &&
                        ((rd_count + RD_CW'(rd_pend)) < RD_CW'(RD_FIFO_DEPTH));
        if (rd_go) begin
            rd_state_next = (rd_size == '0) ? RD_DONE : RD_ACTIVE;
        end else if (rd_state == RD_ACTIVE && rd_pop &&
                     (rd_popped + SIZE_WIDTH'(1)) == rd_size_q) begin
            rd_state_next = RD_DONE;
        end
        rd_done = (rd_state == RD_DONE);
        empty   = (rd_count == '0);
        rd_data = empty ? '0 : rd_fifo[rd_rp];
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (rst) rd_state <= RD_IDLE;
        else     rd_state <= rd_state_next;
    end

    // Read address, counters, FIFO pointers and occupancy; rd_go flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cur_addr <= '0;
            rd_size_q   <= '0;
            rd_issued   <= '0;
            rd_popped   <= '0;
            rd_pend     <= 1'b0;
            rd_wp       <= '0;
            rd_rp       <= '0;
            rd_count    <= '0;
        end else if (rd_go) begin
            rd_cur_addr <= rd_addr;
            rd_size_q   <= rd_size;
            rd_issued   <= '0;
            rd_popped   <= '0;
            rd_pend     <= 1'b0;
            rd_wp       <= '0;
            rd_rp       <= '0;
            rd_count    <= '0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue) begin
                rd_cur_addr <= rd_cur_addr + ADDR_WIDTH'(1);
                rd_issued   <= rd_issued + SIZE_WIDTH'(1);
            end
            if (rd_pend) rd_wp <= rd_wp + RD_PW'(1);
            if (rd_pop) begin
                rd_rp     <= rd_rp + RD_PW'(1);
                rd_popped <= rd_popped + SIZE_WIDTH'(1);
            end
            case ({rd_pend, rd_pop})
                2'b10:   rd_count <= rd_count + RD_CW'(1);
                2'b01:   rd_count <= rd_count - RD_CW'(1);
                default: rd_count <= rd_count;
            endcase
        end
    end

    // Read FIFO storage: captures the RAM output register one cycle after issue.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are not reset; the pointers and occupancy define what is valid.
        if (rd_pend) rd_fifo[rd_wp] <= rd_ram_q;
    end

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    wr_state_t             wr_state, wr_state_next;
    logic [ADDR_WIDTH-1:0] wr_cur_addr;
    logic [SIZE_WIDTH-1:0] wr_size_q;
    logic [SIZE_WIDTH-1:0] wr_accepted;
    logic [SIZE_WIDTH-1:0] wr_committed;
    logic [DATA_WIDTH-1:0] wr_fifo [WR_FIFO_DEPTH];
    logic [WR_PW-1:0]      wr_wp, wr_rp;
    logic [WR_CW-1:0]      wr_count;
    logic                  wr_push;
    logic                  wr_drain;

    // Write FSM next state, push/drain strobes and status outputs.
    always_comb begin
        wr_state_next = wr_state;
        full          = (wr_state != WR_ACTIVE) ||
                        (wr_count == WR_CW'(WR_FIFO_DEPTH)) ||
                        (wr_accepted == wr_size_q);
        wr_push       = wr_en && !full && !wr_go;
        wr_drain      = (wr_state == WR_ACTIVE) && (wr_count != '0) &&
                        !wr_go && !rst && !wr_stall;
        if (wr_go) begin
            wr_state_next = (wr_size == '0) ? WR_DONE : WR_ACTIVE;
        end else if (wr_state == WR_ACTIVE && wr_drain &&
                     (wr_committed + SIZE_WIDTH'(1)) == wr_size_q) begin
            wr_state_next = WR_DONE;
        end
        wr_done = (wr_state == WR_DONE);
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) wr_state <= WR_IDLE;
        else     wr_state <= wr_state_next;
    end

    // Write address, counters, FIFO pointers, occupancy and commit pulse; wr_go flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cur_addr       <= '0;
            wr_size_q         <= '0;
            wr_accepted       <= '0;
            wr_committed      <= '0;
            wr_wp             <= '0;
            wr_rp             <= '0;
            wr_count          <= '0;
            host_wr_completed <= 1'b0;
        end else begin
            host_wr_completed <= wr_drain;
            if (wr_go) begin
                wr_cur_addr  <= wr_addr;
                wr_size_q    <= wr_size;
                wr_accepted  <= '0;
                wr_committed <= '0;
                wr_wp        <= '0;
                wr_rp        <= '0;
                wr_count     <= '0;
            end else begin
                if (wr_push) begin
                    wr_wp       <= wr_wp + WR_PW'(1);
                    wr_accepted <= wr_accepted + SIZE_WIDTH'(1);
                end
                if (wr_drain) begin
                    wr_rp        <= wr_rp + WR_PW'(1);
                    wr_cur_addr  <= wr_cur_addr + ADDR_WIDTH'(1);
                    wr_committed <= wr_committed + SIZE_WIDTH'(1);
                end
                case ({wr_push, wr_drain})
                    2'b10:   wr_count <= wr_count + WR_CW'(1);
                    2'b01:   wr_count <= wr_count - WR_CW'(1);
                    default: wr_count <= wr_count;
                endcase
            end
        end
    end

    // Write FIFO storage.
    always_ff @(posedge clk) begin
        if (wr_push) wr_fifo[wr_wp] <= wr_data;
    end

    // Dual-port RAM: the read port samples the old contents when both ports hit one address.
    always_ff @(posedge clk) begin
        if (wr_drain) mem[wr_cur_addr] <= wr_fifo[wr_rp];
        if (rd_issue) rd_ram_q <= mem[rd_cur_addr];
    end

endmodule

// File: tb/tb_dma_bram_responder.sv
// Self-checking bench for dma_bram_responder: randomized transfers against a
// line-addressed array model, with a scoreboard queue checked by a monitor.
module tb_dma_bram_responder;

    localparam int DW    = 512;
    localparam int AW    = 10;
    localparam int SW    = 16;
    localparam int LINES = 2**AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_go;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_size;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          rd_done;
    logic          wr_go;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] wr_size;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          wr_done;
    logic          host_wr_completed;

    dma_bram_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
        .RD_FIFO_DEPTH(4), .WR_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_go(rd_go), .rd_addr(rd_addr), .rd_size(rd_size), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .rd_done(rd_done),
        .wr_go(wr_go), .wr_addr(wr_addr), .wr_size(wr_size), .wr_en(wr_en),
        .wr_data(wr_data), .full(full), .wr_done(wr_done),
        .host_wr_completed(host_wr_completed)
    );

    always #5 clk = ~clk;

    int            checks    = 0;
    int            errors    = 0;
    int            pulse_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] ref_mem [LINES];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: every accepted pop is compared against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rd_en && !empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_data_unexpected: got %0h with no line expected", rd_data);
                end else begin
                    check("rd_data", rd_data, exp_q.pop_front());
                end
            end
            if (host_wr_completed) pulse_cnt++;
        end
    end

    // Write transfer; model updated as each line is accepted.
    task automatic do_write(input int addr, input int size, input logic [DW-1:0] base,
                            input bit rnd, input bit gaps);
        int            sent = 0;
        int            cyc  = 0;
        int            p0;
        logic [DW-1:0] d;
        p0      = pulse_cnt;
        wr_addr = addr[AW-1:0];
        wr_size = size[SW-1:0];
        wr_go   = 1'b1;
        tick();
        wr_go = 1'b0;
        while ((sent < size || !wr_done) && cyc < 2000) begin
            if (sent < size && !full && (!gaps || $urandom_range(0, 3) != 0)) begin
                d       = rnd ? rand_line() : base + DW'(sent);
                wr_en   = 1'b1;
                wr_data = d;
                ref_mem[(addr + sent) % LINES] = d;
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            cyc++;
        end
        wr_en = 1'b0;
        check("wr_done", DW'(wr_done), DW'(1));
        tick();
        check("wr_pulses", DW'(pulse_cnt - p0), DW'(size));
    endtask

    // Read transfer. mode 0: rd_en high, 1: random rd_en, 2: rd_en low 20 cycles then high.
    task automatic do_read(input int addr, input int size, input int mode, input bit chk_lat);
        int cyc = 0;
        for (int i = 0; i < size; i++) exp_q.push_back(ref_mem[(addr + i) % LINES]);
        rd_addr = addr[AW-1:0];
        rd_size = size[SW-1:0];
        rd_go   = 1'b1;
        rd_en   = (mode == 0);
        tick();
        rd_go = 1'b0;
        if (chk_lat) begin
            check("empty_after_go", DW'(empty), DW'(1));
            tick();
            check("empty_cycle1", DW'(empty), DW'(1));
            tick();
            check("empty_cycle2", DW'(empty), DW'(0));
        end
        if (mode == 2) begin
            rd_en = 1'b0;
            repeat (20) tick();
            check("stall_empty", DW'(empty), DW'(0));
            check("stall_rd_done", DW'(rd_done), DW'(0));
            check("stall_nothing_popped", DW'(exp_q.size()), DW'(size));
        end
        while (!rd_done && cyc < 4000) begin
            rd_en = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
        end
        rd_en = 1'b0;
        check("rd_done", DW'(rd_done), DW'(1));
        check("rd_all_lines_seen", DW'(exp_q.size()), DW'(0));
        exp_q.delete();
    endtask

    initial begin
        int p0;
        int cyc;
        rst = 1'b1; rd_go = 1'b0; rd_addr = '0; rd_size = '0; rd_en = 1'b0;
        wr_go = 1'b0; wr_addr = '0; wr_size = '0; wr_en = 1'b0; wr_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset values
        check("reset_empty", DW'(empty), DW'(1));
        check("reset_rd_done", DW'(rd_done), DW'(0));
        check("reset_full", DW'(full), DW'(1));
        check("reset_wr_done", DW'(wr_done), DW'(0));
        check("reset_hwc", DW'(host_wr_completed), DW'(0));
        check("reset_rd_data", rd_data, '0);

        // Preload 0..7 with k+100, read back with latency check
        do_write(0, 8, DW'(100), 1'b0, 1'b0);
        do_read(0, 8, 0, 1'b1);

        // Wrapping write at 1020, read back across the wrap
        do_write(1020, 8, DW'('hA0), 1'b0, 1'b0);
        do_read(1020, 8, 1, 1'b0);

        // Zero-size read
        rd_addr = '0; rd_size = '0; rd_go = 1'b1;
        tick();
        rd_go = 1'b0;
        check("zero_rd_done", DW'(rd_done), DW'(1));
        check("zero_empty", DW'(empty), DW'(1));
        repeat (4) tick();
        check("zero_empty_later", DW'(empty), DW'(1));

        // Back-pressured 16-line read, then drain in order
        do_write(300, 16, '0, 1'b1, 1'b1);
        do_read(300, 16, 2, 1'b0);

        // Same-cycle read and write of address 5
        do_write(5, 1, DW'('h11), 1'b0, 1'b0);
        exp_q.push_back(ref_mem[5]);
        p0 = pulse_cnt;
        wr_addr = AW'(5); wr_size = SW'(1); wr_go = 1'b1;
        tick();
        wr_go = 1'b0;
        wr_en = 1'b1; wr_data = DW'('h22);
        rd_addr = AW'(5); rd_size = SW'(1); rd_go = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_go = 1'b0;
        ref_mem[5] = DW'('h22);
        cyc = 0;
        while (!(rd_done && wr_done) && cyc < 100) begin
            tick();
            cyc++;
        end
        rd_en = 1'b0;
        tick();
        check("collide_rd_done", DW'(rd_done), DW'(1));
        check("collide_wr_done", DW'(wr_done), DW'(1));
        check("collide_old_seen", DW'(exp_q.size()), DW'(0));
        check("collide_pulse", DW'(pulse_cnt - p0), DW'(1));
        do_read(5, 1, 0, 1'b0);

        // Reset in the middle of an 8-line write after 3 commits
        p0 = pulse_cnt;
        wr_addr = AW'(200); wr_size = SW'(8); wr_go = 1'b1;
        tick();
        wr_go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = rand_line();
            ref_mem[200 + i] = wr_data;
            tick();
        end
        wr_en = 1'b0;
        repeat (3) tick();
        check("midrst_pulses_before", DW'(pulse_cnt - p0), DW'(3));
        check("midrst_not_done", DW'(wr_done), DW'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_full", DW'(full), DW'(1));
        check("midrst_wr_done", DW'(wr_done), DW'(0));
        check("midrst_empty", DW'(empty), DW'(1));
        p0 = pulse_cnt;
        repeat (6) tick();
        check("midrst_no_pulses", DW'(pulse_cnt - p0), DW'(0));
        do_read(200, 3, 0, 1'b0);
        do_read(0, 8, 1, 1'b0);

        // Randomized write/read pairs
        for (int it = 0; it < 12; it++) begin
            int waddr, wsize, off, rsize;
            waddr = $urandom_range(0, LINES - 1);
            wsize = $urandom_range(1, 12);
            do_write(waddr, wsize, '0, 1'b1, 1'b1);
            off   = $urandom_range(0, wsize - 1);
            rsize = $urandom_range(1, wsize - off);
            do_read(waddr + off, rsize, 1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
